// File: rtl/intpol2_d4_ctrl_fsm.sv
// Control FSM for the 4x quadratic interpolator.
// Sequences one frame: soft clear, prime the three-sample coefficient
// window, issue four interpolation phases per input sample, drain the
// datapath pipeline, then pulse done.
module intpol2_d4_ctrl_fsm #(
  parameter int PIPE_LAT = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       abort,
  input  logic       Empty,
  input  logic       Afull,
  input  logic       comp_addr,
  input  logic       comp_cnt,
  output logic       clear,
  output logic       busy,
  output logic       en_M_addr,
  output logic       Read_Enable,
  output logic       en_sum,
  output logic [1:0] phase,
  output logic       Write_Enable,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          phase_q, phase_d;
  logic [PIPE_LAT-1:0] valid_q, valid_d;
  logic                issue;

  // State register, phase counter and issue-valid shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, phase advance, issue tracking and Mealy FIFO/counter strobes.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    valid_d     = valid_q << 1;
    issue       = 1'b0;
    Read_Enable = 1'b0;
    en_M_addr   = 1'b0;
    en_sum      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end

      S_CLR: begin
        state_d = S_PRIME;
      end

      S_PRIME: begin
        // Once the window reports loaded, stop popping and start issuing.
        if (comp_addr) begin
          state_d = S_RUN;
        end else if (!Empty) begin
          Read_Enable = 1'b1;
          en_M_addr   = 1'b1;
        end
      end

      S_RUN: begin
        // Only the phase-3 issue consumes a new sample, so Empty only
        // matters there; the last sample of the frame needs no pop.
        issue = !Afull && ((phase_q != 2'd3) || !Empty || comp_cnt);
        if (issue) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (comp_cnt) begin
              state_d = S_FLUSH;
            end else begin
              Read_Enable = 1'b1;
              en_sum      = 1'b1;
            end
          end
        end
      end

      S_FLUSH: begin
        // Wait until every issued result has been written out.
        if (valid_q == '0) state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    valid_d[0] = issue;

    // Abort wins over everything: drop in-flight writes, no done pulse.
    if (abort) begin
      state_d     = S_IDLE;
      phase_d     = 2'd0;
      valid_d     = '0;
      issue       = 1'b0;
      Read_Enable = 1'b0;
      en_M_addr   = 1'b0;
      en_sum      = 1'b0;
    end
  end

  assign clear        = (state_q == S_CLR);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign phase        = phase_q;
  assign Write_Enable = valid_q[PIPE_LAT-1];

endmodule
